// File: rtl/radiant_evhdr_pkg.sv
// Shared constants, FSM state encoding and filler helper for the event header reader.
package radiant_evhdr_pkg;

  localparam int          NUM_DW_DEF   = 8;
  localparam logic [8:0]  HDR_BASE_DEF = 9'h100;
  localparam logic [31:0] IDENT_DEF    = 32'h5244_4530;
  localparam logic [31:0] FILLER_BASE  = 32'hBADD_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_PUSH,
    ST_POP
  } hdr_state_e;

  // Filler dword pushed for any header slot that could not be read.
  function automatic logic [31:0] filler_word(input logic [15:0] idx);
    return FILLER_BASE | {16'h0000, idx};
  endfunction

endpackage

// File: rtl/radiant_event_hdr_reader_if.sv
// Wishbone classic read bus plus the outgoing header stream of the event header reader.
interface radiant_event_hdr_reader_if #(
  parameter int ADR_W = 9
) ();

  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_dat_i;
  logic             wbm_ack_i;
  logic             wbm_err_i;

  logic [31:0]      hdr_tdata_o;
  logic             hdr_tvalid_o;
  logic             hdr_tready_i;
  logic             hdr_tlast_o;
  logic [1:0]       hdr_tuser_o;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output hdr_tdata_o, hdr_tvalid_o, hdr_tlast_o, hdr_tuser_o,
    input  hdr_tready_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  hdr_tdata_o, hdr_tvalid_o, hdr_tlast_o, hdr_tuser_o,
    output hdr_tready_i
  );

endinterface

// File: rtl/radiant_wb_read_timeout.sv
// Single-read Wishbone classic master: holds cyc/stb and the address from start until ack,
// err or TIMEOUT cycles have passed; reports completion combinationally in the final cycle.
module radiant_wb_read_timeout #(
  parameter int ADR_W   = 9,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [ADR_W-1:0] adr_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic [ADR_W-1:0] adr_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i,
  input  logic             err_i,
  output logic             done_o,
  output logic             ok_o,
  output logic [31:0]      data_o
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic             cyc_q;
  logic [ADR_W-1:0] adr_q;
  logic [TMR_W-1:0] tmr_q;
  logic             timeout;

  // Terminations are only honoured while our own cycle is open.
  assign timeout = cyc_q && (tmr_q == TMR_W'(TIMEOUT - 1));
  assign done_o  = cyc_q && (ack_i || err_i || timeout);
  assign ok_o    = cyc_q && ack_i;
  assign data_o  = dat_i;
  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign adr_o   = adr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q <= 1'b0;
      adr_q <= '0;
      tmr_q <= '0;
    end else if (start_i) begin
      cyc_q <= 1'b1;
      adr_q <= adr_i;
      tmr_q <= '0;
    end else if (cyc_q) begin
      if (done_o) begin
        cyc_q <= 1'b0;
      end
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

endmodule

// File: rtl/radiant_event_hdr_reader.sv
// Reads one event header per DMA request over Wishbone, checks the identifier dword and
// forwards the header as a NUM_DW-beat stream frame, then pops the DMA-request FIFO.
module radiant_event_hdr_reader
  import radiant_evhdr_pkg::*;
#(
  parameter int               ADR_W    = 9,
  parameter logic [ADR_W-1:0] HDR_BASE = ADR_W'(HDR_BASE_DEF),
  parameter int               NUM_DW   = NUM_DW_DEF,
  parameter logic [31:0]      IDENT    = IDENT_DEF,
  parameter int               TIMEOUT  = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic                        event_ready_i,
  input  logic                        event_ready_type_i,
  output logic                        event_readout_ready_o,
  input  logic                        clr_err_i,
  output logic                        ident_err_o,
  output logic                        bus_err_o,
  output logic [31:0]                 hdr_count_o,
  radiant_event_hdr_reader_if.master  bus
);

  localparam int               IDX_W    = (NUM_DW > 1) ? $clog2(NUM_DW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DW - 1);

  hdr_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ev_type_q, ev_type_d;
  logic             frame_err_q, frame_err_d;
  logic [31:0]      tdata_q, tdata_d;
  logic             ident_err_q, ident_err_d;
  logic             bus_err_q, bus_err_d;
  logic [31:0]      count_q, count_d;
  logic             ident_set, bus_set;

  logic             rd_start, rd_done, rd_ok;
  logic [31:0]      rd_data;
  logic [ADR_W-1:0] rd_adr;

  // The read is launched on the edge that enters REQ, so it uses the next index.
  assign rd_adr = HDR_BASE + (ADR_W'(idx_d) << 2);

  radiant_wb_read_timeout #(
    .ADR_W   (ADR_W),
    .TIMEOUT (TIMEOUT)
  ) u_rd (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (rd_start),
    .adr_i   (rd_adr),
    .cyc_o   (bus.wbm_cyc_o),
    .stb_o   (bus.wbm_stb_o),
    .adr_o   (bus.wbm_adr_o),
    .dat_i   (bus.wbm_dat_i),
    .ack_i   (bus.wbm_ack_i),
    .err_i   (bus.wbm_err_i),
    .done_o  (rd_done),
    .ok_o    (rd_ok),
    .data_o  (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ev_type_d   = ev_type_q;
    frame_err_d = frame_err_q;
    tdata_d     = tdata_q;
    count_d     = count_q;
    rd_start    = 1'b0;
    ident_set   = 1'b0;
    bus_set     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && event_ready_i) begin
          ev_type_d   = event_ready_type_i;
          frame_err_d = 1'b0;
          idx_d       = '0;
          rd_start    = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rd_done) begin
          state_d = ST_PUSH;
          if (rd_ok) begin
            tdata_d = rd_data;
            if ((idx_q == '0) && (rd_data != IDENT)) begin
              ident_set   = 1'b1;
              frame_err_d = 1'b1;
            end
          end else begin
            tdata_d     = filler_word(16'(idx_q));
            frame_err_d = 1'b1;
            bus_set     = 1'b1;
          end
        end
      end
      ST_PUSH: begin
        if (bus.hdr_tready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_POP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            // A broken frame is padded out without touching the bus again.
            if (frame_err_q) begin
              tdata_d = filler_word(16'(idx_d));
            end else begin
              rd_start = 1'b1;
              state_d  = ST_REQ;
            end
          end
        end
      end
      ST_POP: begin
        count_d = count_q + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ident_err_d = ident_set | (ident_err_q & ~clr_err_i);
    bus_err_d   = bus_set | (bus_err_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ev_type_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tdata_q     <= '0;
      ident_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ev_type_q   <= ev_type_d;
      frame_err_q <= frame_err_d;
      tdata_q     <= tdata_d;
      ident_err_q <= ident_err_d;
      bus_err_q   <= bus_err_d;
      count_q     <= count_d;
    end
  end

  assign bus.wbm_we_o          = 1'b0;
  assign bus.wbm_sel_o         = 4'hF;
  assign bus.hdr_tvalid_o      = (state_q == ST_PUSH);
  assign bus.hdr_tlast_o       = (state_q == ST_PUSH) && (idx_q == LAST_IDX);
  assign bus.hdr_tdata_o       = tdata_q;
  assign bus.hdr_tuser_o       = {frame_err_q, ev_type_q};
  assign event_readout_ready_o = (state_q == ST_POP);
  assign ident_err_o           = ident_err_q;
  assign bus_err_o             = bus_err_q;
  assign hdr_count_o           = count_q;

endmodule

// File: tb/tb_radiant_event_hdr_reader.sv
// Randomized bench for radiant_event_hdr_reader: Wishbone slave, FWFT event FIFO and
// stream sink models, with expected beats derived per event from the header rules.
module tb_radiant_event_hdr_reader;

  localparam logic [31:0] IDENT = 32'h5244_4530;
  localparam logic [31:0] FILL  = 32'hBADD_0000;
  localparam int          BASE  = 256;

  typedef struct packed {
    logic [7:0][31:0] w;
    logic             typ;
    logic [3:0]       noack;
    logic [3:0]       erri;
    logic [1:0]       lat;
  } ev_t;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enable_i = 1'b1;
  logic        event_ready_i = 1'b0;
  logic        event_ready_type_i = 1'b0;
  logic        clr_err_i = 1'b0;
  logic        event_readout_ready_o;
  logic        ident_err_o;
  logic        bus_err_o;
  logic [31:0] hdr_count_o;

  radiant_event_hdr_reader_if #(.ADR_W(9)) bus_if ();

  radiant_event_hdr_reader dut (
    .clk_i                 (clk_i),
    .rst_n_i               (rst_n_i),
    .enable_i              (enable_i),
    .event_ready_i         (event_ready_i),
    .event_ready_type_i    (event_ready_type_i),
    .event_readout_ready_o (event_readout_ready_o),
    .clr_err_i             (clr_err_i),
    .ident_err_o           (ident_err_o),
    .bus_err_o             (bus_err_o),
    .hdr_count_o           (hdr_count_o),
    .bus                   (bus_if)
  );

  always #5 clk_i = ~clk_i;

  ev_t   ev_q[$];
  beat_t exp_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    reads_obs = 0, reads_exp = 0, pops_obs = 0, frames_exp = 0, beats_obs = 0;
  logic  exp_ident = 1'b0, exp_bus = 1'b0;
  int    tready_pct = 100;
  int    cyc_no = 0, t_rdy = -1, t_first_v = -1, t_pop = -1;
  logic  prev_rdy = 1'b0;
  int    wcnt = 0, cur_lat = 1, cyc_len = 0, last_timeout_len = 0, rd_exp_idx = 0;
  logic  term_seen = 1'b0, stall_prev = 1'b0;
  beat_t stall_beat;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic ev_t make_ev(input logic [31:0] w0, input logic [3:0] noack,
                                  input logic [3:0] erri, input logic [1:0] lat);
    ev_t e;
    for (int k = 0; k < 8; k++) e.w[k] = $urandom;
    e.w[0]  = w0;
    e.typ   = 1'($urandom_range(0, 1));
    e.noack = noack;
    e.erri  = erri;
    e.lat   = lat;
    return e;
  endfunction

  // Expected frame: each slot is read until the first failure or bad identifier,
  // after which every remaining slot carries the filler pattern.
  task automatic push_event(input ev_t e);
    logic ferr = 1'b0;
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      if (ferr) begin
        b.d = FILL | k;
      end else if (k == int'(e.noack) || k == int'(e.erri)) begin
        b.d = FILL | k;
        ferr = 1'b1;
        exp_bus = 1'b1;
      end else begin
        b.d = e.w[k];
        reads_exp++;
        if (k == 0 && e.w[0] != IDENT) begin
          ferr = 1'b1;
          exp_ident = 1'b1;
        end
      end
      b.last = (k == 7);
      b.user = {ferr, e.typ};
      exp_q.push_back(b);
    end
    frames_exp++;
    ev_q.push_back(e);
  endtask

  // Reactive models evaluated mid-cycle: FIFO, Wishbone slave, stream sink.
  always @(negedge clk_i) begin
    int ridx;
    logic [2:0] sidx;
    beat_t cur, e;
    cyc_no++;
    if (event_readout_ready_o) begin
      pops_obs++;
      t_pop = cyc_no;
      rd_exp_idx = 0;
      if (ev_q.size() > 0) void'(ev_q.pop_front());
    end
    event_ready_i = (ev_q.size() > 0);
    event_ready_type_i = (ev_q.size() > 0) ? ev_q[0].typ : 1'b0;
    if (event_ready_i && !prev_rdy) begin
      t_rdy = cyc_no;
      t_first_v = -1;
    end
    prev_rdy = event_ready_i;

    if (bus_if.wbm_cyc_o && bus_if.wbm_stb_o && ev_q.size() > 0) begin
      wcnt++;
      cyc_len++;
      ridx = (int'(bus_if.wbm_adr_o) - BASE) >>> 2;
      sidx = ridx[2:0];
      if (wcnt == 1) cur_lat = (ev_q[0].lat != 0) ? int'(ev_q[0].lat) : int'($urandom_range(1, 3));
      bus_if.wbm_ack_i = 1'b0;
      bus_if.wbm_err_i = 1'b0;
      bus_if.wbm_dat_i = $urandom;
      if (wcnt == cur_lat + 1 && ridx != int'(ev_q[0].noack)) begin
        chk("rd_adr", 32'(bus_if.wbm_adr_o), BASE + 4 * rd_exp_idx);
        term_seen = 1'b1;
        rd_exp_idx++;
        if (ridx == int'(ev_q[0].erri)) begin
          bus_if.wbm_err_i = 1'b1;
        end else begin
          bus_if.wbm_ack_i = 1'b1;
          bus_if.wbm_dat_i = ev_q[0].w[sidx];
          reads_obs++;
        end
      end
    end else begin
      if (cyc_len > 0 && !term_seen) last_timeout_len = cyc_len;
      // Stray terminations while no cycle is open must be ignored.
      bus_if.wbm_ack_i = ($urandom_range(0, 9) == 0);
      bus_if.wbm_err_i = ($urandom_range(0, 19) == 0);
      bus_if.wbm_dat_i = $urandom;
      wcnt = 0;
      cyc_len = 0;
      term_seen = 1'b0;
    end

    bus_if.hdr_tready_i = ($urandom_range(0, 99) < tready_pct);
    cur = {bus_if.hdr_tdata_o, bus_if.hdr_tlast_o, bus_if.hdr_tuser_o};
    if (bus_if.hdr_tvalid_o) chk("no_cyc_in_push", 32'(bus_if.wbm_cyc_o), 0);
    if (stall_prev) begin
      chk("stall_valid", 32'(bus_if.hdr_tvalid_o), 1);
      chk("stall_beat", 32'(cur), 32'(stall_beat));
    end
    stall_prev = 1'b0;
    if (bus_if.hdr_tvalid_o) begin
      if (t_first_v < 0) t_first_v = cyc_no;
      if (bus_if.hdr_tready_i) begin
        beats_obs++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus_if.hdr_tdata_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", bus_if.hdr_tdata_o, e.d);
          chk("tlast", 32'(bus_if.hdr_tlast_o), 32'(e.last));
          chk("tuser", 32'(bus_if.hdr_tuser_o), 32'(e.user));
        end
      end else begin
        stall_prev = 1'b1;
        stall_beat = cur;
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i); #1;
      if (ev_q.size() == 0 && exp_q.size() == 0) break;
    end
    chk("drain", 32'(ev_q.size() + exp_q.size()), 0);
    repeat (2) @(negedge clk_i);
    #1;
  endtask

  task automatic clear_errs();
    @(negedge clk_i); #1 clr_err_i = 1'b1;
    @(negedge clk_i); #1 clr_err_i = 1'b0;
    exp_ident = 1'b0;
    exp_bus = 1'b0;
    chk("ident_err_clr", 32'(ident_err_o), 0);
    chk("bus_err_clr", 32'(bus_err_o), 0);
  endtask

  task automatic check_totals(input string tag);
    chk({tag, "_count"}, hdr_count_o, frames_exp);
    chk({tag, "_pops"}, pops_obs, frames_exp);
    chk({tag, "_reads"}, reads_obs, reads_exp);
    chk({tag, "_ident_err"}, 32'(ident_err_o), 32'(exp_ident));
    chk({tag, "_bus_err"}, 32'(bus_err_o), 32'(exp_bus));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_beats, base_pops;
    logic [3:0] fidx, na, er;
    bus_if.wbm_ack_i = 1'b0;
    bus_if.wbm_err_i = 1'b0;
    bus_if.wbm_dat_i = '0;
    bus_if.hdr_tready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_cyc", 32'(bus_if.wbm_cyc_o), 0);
    chk("rst_stb", 32'(bus_if.wbm_stb_o), 0);
    chk("rst_we", 32'(bus_if.wbm_we_o), 0);
    chk("rst_adr", 32'(bus_if.wbm_adr_o), 0);
    chk("rst_tvalid", 32'(bus_if.hdr_tvalid_o), 0);
    chk("rst_tlast", 32'(bus_if.hdr_tlast_o), 0);
    chk("rst_tuser", 32'(bus_if.hdr_tuser_o), 0);
    chk("rst_tdata", bus_if.hdr_tdata_o, 0);
    chk("rst_pop", 32'(event_readout_ready_o), 0);
    chk("rst_ident_err", 32'(ident_err_o), 0);
    chk("rst_bus_err", 32'(bus_err_o), 0);
    chk("rst_count", hdr_count_o, 0);
    #1 rst_n_i = 1'b1;

    // Single clean event, 1-cycle ack, sink always ready: latency and frame length.
    tready_pct = 100;
    push_event(make_ev(IDENT, 4'd15, 4'd15, 2'd1));
    wait_done(200);
    chk("latency", t_first_v - t_rdy, 3);
    chk("frame_cycles", t_pop - t_rdy + 1, 26);
    check_totals("single");

    // Three back-to-back events with a stalling sink and random ack latency.
    tready_pct = 50;
    for (int i = 0; i < 3; i++) push_event(make_ev(IDENT, 4'd15, 4'd15, 2'd0));
    wait_done(1500);
    check_totals("b2b");

    // Bad identifier: frame still emitted, flagged, then the sticky flag is cleared.
    push_event(make_ev(32'h1234_5678, 4'd15, 4'd15, 2'd0));
    wait_done(500);
    check_totals("ident");
    clear_errs();

    // No ack on dword 3: timeout after 255 cycles, remainder is filler.
    tready_pct = 100;
    push_event(make_ev(IDENT, 4'd3, 4'd15, 2'd1));
    wait_done(2000);
    chk("timeout_len", last_timeout_len, 255);
    check_totals("timeout");
    clear_errs();

    // Bus error on dword 5.
    tready_pct = 70;
    push_event(make_ev(IDENT, 4'd15, 4'd5, 2'd0));
    wait_done(800);
    check_totals("buserr");
    clear_errs();

    // enable_i dropped mid-frame: current frame finishes, the pending one waits.
    tready_pct = 100;
    base_beats = beats_obs;
    base_pops = pops_obs;
    push_event(make_ev(IDENT, 4'd15, 4'd15, 2'd1));
    push_event(make_ev(IDENT, 4'd15, 4'd15, 2'd1));
    for (int i = 0; i < 200 && beats_obs < base_beats + 4; i++) begin
      @(negedge clk_i); #1;
    end
    enable_i = 1'b0;
    for (int i = 0; i < 200 && pops_obs < base_pops + 1; i++) begin
      @(negedge clk_i); #1;
    end
    repeat (30) @(negedge clk_i);
    #1;
    chk("en_pending", 32'(ev_q.size()), 1);
    chk("en_count", hdr_count_o, frames_exp - 1);
    chk("en_idle_cyc", 32'(bus_if.wbm_cyc_o), 0);
    chk("en_idle_tvalid", 32'(bus_if.hdr_tvalid_o), 0);
    enable_i = 1'b1;
    wait_done(500);
    check_totals("enable");

    // Randomized mix of clean, bad-identifier, timeout and error events.
    tready_pct = 70;
    for (int i = 0; i < 12; i++) begin
      fidx = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(0, 7)) : 4'd15;
      na = ($urandom_range(0, 1) == 0) ? fidx : 4'd15;
      er = (na == 4'd15) ? fidx : 4'd15;
      push_event(make_ev(($urandom_range(0, 99) < 15) ? 32'($urandom) : IDENT, na, er, 2'd0));
    end
    wait_done(12000);
    check_totals("random");
    clear_errs();

    // Asynchronous reset while a read is open.
    tready_pct = 100;
    push_event(make_ev(IDENT, 4'd15, 4'd15, 2'd2));
    for (int i = 0; i < 100 && !bus_if.wbm_cyc_o; i++) begin
      @(negedge clk_i); #1;
    end
    chk("pre_rst_cyc", 32'(bus_if.wbm_cyc_o), 1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("arst_cyc", 32'(bus_if.wbm_cyc_o), 0);
    chk("arst_stb", 32'(bus_if.wbm_stb_o), 0);
    chk("arst_tvalid", 32'(bus_if.hdr_tvalid_o), 0);
    chk("arst_count", hdr_count_o, 0);
    ev_q.delete();
    exp_q.delete();
    frames_exp = 0;
    reads_obs = 0;
    reads_exp = 0;
    pops_obs = 0;
    rd_exp_idx = 0;
    exp_ident = 1'b0;
    exp_bus = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    push_event(make_ev(IDENT, 4'd15, 4'd15, 2'd0));
    wait_done(300);
    check_totals("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
